// File: rtl/exe_mem_pipe.sv
// EX/MEM pipeline register with valid/stall/flush, multi-cycle memory hold FSM and sticky error flag.
// Optional stall-cycle performance counter enabled by defining EXE_MEM_PERF_EN.
module exe_mem_pipe #(
  parameter int                DATA_W      = 16,
  parameter int                REG_W       = 4,
  parameter logic [REG_W-1:0]  REG_INVALID = {REG_W{1'b1}},
  parameter int                MEM_CYC     = 1
) (
  input  logic              emi_clk,
  input  logic              emi_rst,
  input  logic              emi_valid,
  input  logic              emi_stall,
  input  logic              emi_flush,
  input  logic [DATA_W-1:0] emi_instr,
  input  logic [DATA_W-1:0] emi_pc,
  input  logic [DATA_W-1:0] emi_data,
  input  logic [DATA_W-1:0] emi_mem_addr,
  input  logic [REG_W-1:0]  emi_wreg_addr,
  input  logic [1:0]        emi_rwe,
  output logic              emo_valid,
  output logic [DATA_W-1:0] emo_instr,
  output logic [DATA_W-1:0] emo_pc,
  output logic [DATA_W-1:0] emo_data,
  output logic [DATA_W-1:0] emo_mem_addr,
  output logic [REG_W-1:0]  emo_wreg_addr,
  output logic [1:0]        emo_rwe,
  output logic              emo_stall_req,
  output logic              emo_mem_done,
  output logic              emo_err,
  output logic [15:0]       emo_stall_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       flush_pending;
  logic       done_seen;
  logic       load_bubble;
  logic       load_payload;
  logic       mem_op;
  logic       illegal_rwe;

  assign mem_op      = (emi_rwe == 2'b01) || (emi_rwe == 2'b10);
  assign illegal_rwe = (emi_rwe == 2'b11);

  always_ff @(posedge emi_clk or negedge emi_rst) begin
    if (!emi_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // IDLE decides what loads; WAIT only counts down the memory access.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    load_bubble  = 1'b0;
    load_payload = 1'b0;
    case (state)
      IDLE: begin
        if (emi_flush || flush_pending) begin
          load_bubble = 1'b1;
        end else if (emi_stall) begin
          load_bubble = 1'b0;
        end else if (emi_valid) begin
          load_payload = 1'b1;
          if (mem_op && (MEM_CYC > 1)) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end else begin
          load_bubble = 1'b1;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge emi_clk or negedge emi_rst) begin
    if (!emi_rst) begin
      emo_valid     <= 1'b0;
      emo_instr     <= '0;
      emo_pc        <= '0;
      emo_data      <= '0;
      emo_mem_addr  <= '0;
      emo_wreg_addr <= REG_INVALID;
      emo_rwe       <= 2'b00;
      emo_err       <= 1'b0;
      flush_pending <= 1'b0;
      done_seen     <= 1'b0;
    end else begin
      done_seen <= done_seen | emo_mem_done;
      // A flush during a memory access is deferred, never aborting the access.
      if ((state == WAIT) && emi_flush) begin
        flush_pending <= 1'b1;
      end
      if (load_bubble) begin
        emo_valid     <= 1'b0;
        emo_instr     <= '0;
        emo_pc        <= '0;
        emo_data      <= '0;
        emo_mem_addr  <= '0;
        emo_wreg_addr <= REG_INVALID;
        emo_rwe       <= 2'b00;
        flush_pending <= 1'b0;
        done_seen     <= 1'b0;
      end else if (load_payload) begin
        emo_valid     <= 1'b1;
        emo_instr     <= emi_instr;
        emo_pc        <= emi_pc;
        emo_data      <= emi_data;
        emo_mem_addr  <= emi_mem_addr;
        emo_wreg_addr <= emi_wreg_addr;
        emo_rwe       <= illegal_rwe ? 2'b00 : emi_rwe;
        done_seen     <= 1'b0;
        if (illegal_rwe) begin
          emo_err <= 1'b1;
        end
      end
    end
  end

  assign emo_stall_req = (state == WAIT);
  assign emo_mem_done  = emo_valid && (emo_rwe != 2'b00) && (state == IDLE) && !done_seen;

`ifdef EXE_MEM_PERF_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge emi_clk or negedge emi_rst) begin
    if (!emi_rst) begin
      stall_cnt <= 16'd0;
    end else if (emo_stall_req && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign emo_stall_cnt = stall_cnt;
`else
  assign emo_stall_cnt = 16'd0;
`endif

endmodule

// File: doc/exe_mem_pipe.md
# exe_mem_pipe

Parametrised EX/MEM pipeline register: captures the execute-stage result (instruction, PC, data, write-back register, memory address, read/write enable) and presents it to the memory stage. It adds a valid bit, downstream stall, flush/bubble insertion, and a multi-cycle memory-access hold FSM that back-pressures upstream stages. It also provides a sticky illegal-access flag. It sits between the execute unit and the memory/write-back path and replaces the fixed 16-bit EX/MEM latch.

## Interface
- DATA_W, 16, width of instr, pc, data, mem_addr
- REG_W, 4, width of write-back register address
- REG_INVALID, {REG_W{1'b1}}, write-back address meaning "no write"
- MEM_CYC, 1, cycles an entry with a memory access occupies the stage (1..15)
- emi_clk  in  1  clock, rising edge
- emi_rst  in  1  reset, asynchronous, active-low
- emi_valid  in  1  EX result valid
- emi_stall  in  1  hold request from hazard unit
- emi_flush  in  1  replace next entry with bubble
- emi_instr, emi_pc, emi_data, emi_mem_addr  in  DATA_W  EX payload
- emi_wreg_addr  in  REG_W  write-back register
- emi_rwe  in  2  00 none, 01 read, 10 write, 11 illegal
- emo_valid  out  1  entry valid
- emo_instr, emo_pc, emo_data, emo_mem_addr  out  DATA_W  registered payload
- emo_wreg_addr  out  REG_W  registered write-back register
- emo_rwe  out  2  registered access type (never 11)
- emo_stall_req  out  1  upstream must hold
- emo_mem_done  out  1  one-cycle pulse, memory access completes this cycle
- emo_err  out  1  sticky illegal-rwe flag
- emo_stall_cnt  out  16  stall-cycle counter (see Configuration)

## Operation
- Bubble: valid=0, instr/pc/data/mem_addr=0, wreg_addr=REG_INVALID, rwe=00.
- FSM states: IDLE, WAIT. The 4-bit counter cnt is meaningful in WAIT only.
- In IDLE, at each edge, in priority order:
  - emi_flush or flush_pending: load bubble, clear flush_pending.
  - emi_stall: hold.
  - emi_valid=1: load payload.
  - Otherwise: load bubble.
- Memory-op load: a load with emi_valid=1, rwe in {01,10} and MEM_CYC>1 enters WAIT with cnt=MEM_CYC-1.
- In WAIT:
  - Registers hold regardless of emi_stall.
  - cnt decrements each edge. The edge at which cnt==1 returns the FSM to IDLE.
- emi_flush in WAIT sets flush_pending. The in-flight access is never aborted. The bubble loads at the first IDLE-cycle edge.
- Illegal rwe: a valid load with rwe=11 stores rwe=00, sets emo_err, and otherwise loads normally. emo_err clears only on reset.
- emo_stall_req = (state==WAIT). This is combinational from registered state.
- emo_mem_done = emo_valid & (emo_rwe!=00) & (state==IDLE) & ~done_seen.
  - done_seen sets at the edge after the pulse.
  - done_seen clears on any load.
  - Result: exactly one pulse per entry, even when held by emi_stall.

## Timing
- Reset (asynchronous, any cycle, including mid-WAIT):
  - All outputs become the bubble values; emo_stall_req=0, emo_mem_done=0, emo_err=0, emo_stall_cnt=0.
  - state=IDLE, flush_pending=0, done_seen=0.
- Latency: input to output is 1 cycle.
- A memory entry resides exactly MEM_CYC cycles with no stall:
  - emo_stall_req is high for the first MEM_CYC-1 cycles.
  - emo_mem_done is high in the last cycle.
- MEM_CYC=1: the WAIT state is never entered, and emo_mem_done pulses in the load cycle.
- Back-to-back memory ops: the second loads on the edge ending the first's IDLE cycle and restarts WAIT immediately.
- Flush and stall together in IDLE: flush wins and a bubble loads.

## Configuration
- EXE_MEM_PERF_EN defined:
  - emo_stall_cnt increments every cycle emo_stall_req=1.
  - Saturates at 16'hFFFF; cleared only by reset.
- EXE_MEM_PERF_EN undefined: counter logic absent, emo_stall_cnt tied to 0. The port list is unchanged.

## Test plan
- Reset mid-WAIT (MEM_CYC=4, reset low in the 2nd WAIT cycle) -> outputs immediately bubble, wreg_addr=4'hF, stall_req=0, state IDLE after release.
- MEM_CYC=3, load read (rwe=01, mem_addr=16'h1234) -> stall_req high 2 cycles, mem_done high in cycle 3 only, next payload loads at edge 3.
- Flush asserted in 1st WAIT cycle of a write (MEM_CYC=3) -> the write entry stays for 3 cycles with one mem_done pulse, then a bubble (valid=0) appears instead of the next EX result.
- emi_stall held 5 cycles on an ALU entry (wreg=3, data=16'hBEEF) -> outputs unchanged for 5 cycles, mem_done never pulses; the next value appears one cycle after release.
- Valid load with rwe=11 -> emo_rwe=00, emo_err=1 and stays 1 across 10 subsequent normal loads until reset.
- With EXE_MEM_PERF_EN, MEM_CYC=4, three consecutive memory ops -> emo_stall_cnt=9; without the macro -> 0.
